axi_memtest_master: RTL

// - AXI initiator that exercises the SRAM AXI responder: writes a deterministic

---
 rtl/axi_memtest_master_if.sv | 35 +++
 rtl/axi_memtest_master.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_memtest_master_if.sv
// AXI-style bus bundle between the memory-test initiator and the SRAM bridge
// responder. Word-addressed, 16-bit data, single-bit response codes.
interface axi_memtest_master_if;
    logic        aw_valid;
    logic        aw_ready;
    logic [17:0] aw_addr;
    logic        aw_prot;
    logic        w_valid;
    logic        w_ready;
    logic [15:0] w_data;
    logic [1:0]  w_strb;
    logic        b_valid;
    logic        b_ready;
    logic        b_resp;
    logic        ar_valid;
    logic        ar_ready;
    logic [17:0] ar_addr;
    logic        ar_prot;
    logic        r_valid;
    logic        r_ready;
    logic [15:0] r_data;
    logic        r_resp;

    modport master (
        output aw_valid, aw_addr, aw_prot, w_valid, w_data, w_strb, b_ready,
               ar_valid, ar_addr, ar_prot, r_ready,
        input  aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_data, r_resp
    );

    modport slave (
        input  aw_valid, aw_addr, aw_prot, w_valid, w_data, w_strb, b_ready,
               ar_valid, ar_addr, ar_prot, r_ready,
        output aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_data, r_resp
    );
endinterface

// File: rtl/axi_memtest_master.sv
// Memory-test AXI initiator: writes a deterministic pattern over
// [BASE, BASE+LEN-1], reads it back, counts mismatches and error responses.
// One transaction outstanding; the whole write pass precedes the read pass.
// Optional build macro AXI_MEMTEST_LFSR_EN switches the pattern from
// idx^SEED to a 16-bit Galois LFSR (taps 16'hB400) seeded with SEED.
module axi_memtest_master #(
    parameter logic [17:0] BASE = 18'h00000,
    parameter int unsigned LEN  = 256,
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic                 a_clk,
    input  logic                 a_rst,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic [15:0]          err_count,
    output logic [17:0]          first_err_addr,
    axi_memtest_master_if.master bus
);

    localparam logic [17:0] LAST_IDX = 18'(LEN - 1);

`ifdef AXI_MEMTEST_LFSR_EN
    // A zero seed would lock the LFSR at zero, so it is forced to one.
    localparam logic [15:0] FIRST_PAT = (SEED == 16'h0000) ? 16'h0001 : SEED;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction
`else
    localparam logic [15:0] FIRST_PAT = SEED;
`endif

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WR   = 3'd1,
        ST_WB   = 3'd2,
        ST_RA   = 3'd3,
        ST_RD   = 3'd4,
        ST_DONE = 3'd5
    } state_t;

    state_t      state_r,  state_nx_s;
    logic [17:0] idx_r,    idx_nx_s;
    logic        aw_valid_r, aw_valid_nx_s;
    logic [17:0] aw_addr_r,  aw_addr_nx_s;
    logic        w_valid_r,  w_valid_nx_s;
    logic [15:0] w_data_r,   w_data_nx_s;
    logic        b_ready_r,  b_ready_nx_s;
    logic        ar_valid_r, ar_valid_nx_s;
    logic [17:0] ar_addr_r,  ar_addr_nx_s;
    logic        r_ready_r,  r_ready_nx_s;
    logic        busy_r,     busy_nx_s;
    logic        done_r,     done_nx_s;
    logic [15:0] err_cnt_r,  err_cnt_nx_s;
    logic [17:0] first_r,    first_nx_s;
`ifdef AXI_MEMTEST_LFSR_EN
    logic [15:0] lfsr_r,     lfsr_nx_s;
`endif

    logic [17:0] idx_inc_s;
    logic [15:0] cur_pat_s;
    logic [15:0] next_pat_s;
    logic        aw_left_s;
    logic        w_left_s;
    logic        err_s;

    // Pattern of the current word and of the word that follows it.
    always_comb begin
        idx_inc_s = idx_r + 18'd1;
`ifdef AXI_MEMTEST_LFSR_EN
        cur_pat_s  = lfsr_r;
        next_pat_s = lfsr_step(lfsr_r);
`else
        cur_pat_s  = idx_r[15:0] ^ SEED;
        next_pat_s = idx_inc_s[15:0] ^ SEED;
`endif
    end

    // Next-state, next-output and error accounting for the test sequencer.
    always_comb begin
        state_nx_s    = state_r;
        idx_nx_s      = idx_r;
        aw_valid_nx_s = aw_valid_r;
        aw_addr_nx_s  = aw_addr_r;
        w_valid_nx_s  = w_valid_r;
        w_data_nx_s   = w_data_r;
        b_ready_nx_s  = b_ready_r;
        ar_valid_nx_s = ar_valid_r;
        ar_addr_nx_s  = ar_addr_r;
        r_ready_nx_s  = r_ready_r;
        busy_nx_s     = busy_r;
        done_nx_s     = done_r;
        err_cnt_nx_s  = err_cnt_r;
        first_nx_s    = first_r;
`ifdef AXI_MEMTEST_LFSR_EN
        lfsr_nx_s     = lfsr_r;
`endif
        err_s         = 1'b0;
        aw_left_s     = aw_valid_r && !bus.aw_ready;
        w_left_s      = w_valid_r && !bus.w_ready;

        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    err_cnt_nx_s  = 16'h0000;
                    first_nx_s    = 18'h00000;
                    done_nx_s     = 1'b0;
                    busy_nx_s     = 1'b1;
                    idx_nx_s      = 18'h00000;
                    aw_valid_nx_s = 1'b1;
                    w_valid_nx_s  = 1'b1;
                    aw_addr_nx_s  = BASE;
                    w_data_nx_s   = FIRST_PAT;
`ifdef AXI_MEMTEST_LFSR_EN
                    lfsr_nx_s     = FIRST_PAT;
`endif
                    state_nx_s    = ST_WR;
                end else begin
                    state_nx_s    = ST_IDLE;
                end
            end
            ST_WR: begin
                // Address and data channels retire independently.
                aw_valid_nx_s = aw_left_s;
                w_valid_nx_s  = w_left_s;
                if (!aw_left_s && !w_left_s) begin
                    b_ready_nx_s = 1'b1;
                    state_nx_s   = ST_WB;
                end else begin
                    state_nx_s   = ST_WR;
                end
            end
            ST_WB: begin
                if (bus.b_valid && b_ready_r) begin
                    err_s        = (bus.b_resp != 1'b0);
                    b_ready_nx_s = 1'b0;
                    if (idx_r == LAST_IDX) begin
                        idx_nx_s      = 18'h00000;
                        ar_valid_nx_s = 1'b1;
                        ar_addr_nx_s  = BASE;
`ifdef AXI_MEMTEST_LFSR_EN
                        lfsr_nx_s     = FIRST_PAT;
`endif
                        state_nx_s    = ST_RA;
                    end else begin
                        idx_nx_s      = idx_inc_s;
                        aw_valid_nx_s = 1'b1;
                        w_valid_nx_s  = 1'b1;
                        aw_addr_nx_s  = BASE + idx_inc_s;
                        w_data_nx_s   = next_pat_s;
`ifdef AXI_MEMTEST_LFSR_EN
                        lfsr_nx_s     = next_pat_s;
`endif
                        state_nx_s    = ST_WR;
                    end
                end else begin
                    state_nx_s = ST_WB;
                end
            end
            ST_RA: begin
                if (ar_valid_r && bus.ar_ready) begin
                    ar_valid_nx_s = 1'b0;
                    r_ready_nx_s  = 1'b1;
                    state_nx_s    = ST_RD;
                end else begin
                    state_nx_s    = ST_RA;
                end
            end
            ST_RD: begin
                if (bus.r_valid && r_ready_r) begin
                    // A bad response and bad data on the same beat count once.
                    err_s        = (bus.r_resp != 1'b0) || (bus.r_data != cur_pat_s);
                    r_ready_nx_s = 1'b0;
                    if (idx_r == LAST_IDX) begin
                        state_nx_s    = ST_DONE;
                    end else begin
                        idx_nx_s      = idx_inc_s;
                        ar_valid_nx_s = 1'b1;
                        ar_addr_nx_s  = BASE + idx_inc_s;
`ifdef AXI_MEMTEST_LFSR_EN
                        lfsr_nx_s     = next_pat_s;
`endif
                        state_nx_s    = ST_RA;
                    end
                end else begin
                    state_nx_s = ST_RD;
                end
            end
            ST_DONE: begin
                busy_nx_s  = 1'b0;
                done_nx_s  = 1'b1;
                state_nx_s = ST_IDLE;
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase

        if (err_s) begin
            if (err_cnt_r != 16'hFFFF) begin
                err_cnt_nx_s = err_cnt_r + 16'd1;
            end else begin
                err_cnt_nx_s = err_cnt_r;
            end
            if (err_cnt_r == 16'h0000) begin
                first_nx_s = BASE + idx_r;
            end else begin
                first_nx_s = first_r;
            end
        end else begin
            err_cnt_nx_s = err_cnt_nx_s;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge a_clk) begin
        if (!a_rst) begin
            state_r    <= ST_IDLE;
            idx_r      <= 18'h00000;
            aw_valid_r <= 1'b0;
            aw_addr_r  <= 18'h00000;
            w_valid_r  <= 1'b0;
            w_data_r   <= 16'h0000;
            b_ready_r  <= 1'b0;
            ar_valid_r <= 1'b0;
            ar_addr_r  <= 18'h00000;
            r_ready_r  <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            err_cnt_r  <= 16'h0000;
            first_r    <= 18'h00000;
`ifdef AXI_MEMTEST_LFSR_EN
            lfsr_r     <= 16'h0000;
`endif
        end else begin
            state_r    <= state_nx_s;
            idx_r      <= idx_nx_s;
            aw_valid_r <= aw_valid_nx_s;
            aw_addr_r  <= aw_addr_nx_s;
            w_valid_r  <= w_valid_nx_s;
            w_data_r   <= w_data_nx_s;
            b_ready_r  <= b_ready_nx_s;
            ar_valid_r <= ar_valid_nx_s;
            ar_addr_r  <= ar_addr_nx_s;
            r_ready_r  <= r_ready_nx_s;
            busy_r     <= busy_nx_s;
            done_r     <= done_nx_s;
            err_cnt_r  <= err_cnt_nx_s;
            first_r    <= first_nx_s;
`ifdef AXI_MEMTEST_LFSR_EN
            lfsr_r     <= lfsr_nx_s;
`endif
        end
    end

    assign busy           = busy_r;
    assign done           = done_r;
    assign err_count      = err_cnt_r;
    assign first_err_addr = first_r;
    assign bus.aw_valid   = aw_valid_r;
    assign bus.aw_addr    = aw_addr_r;
    assign bus.aw_prot    = 1'b0;
    assign bus.w_valid    = w_valid_r;
    assign bus.w_data     = w_data_r;
    assign bus.w_strb     = 2'b11;
    assign bus.b_ready    = b_ready_r;
    assign bus.ar_valid   = ar_valid_r;
    assign bus.ar_addr    = ar_addr_r;
    assign bus.ar_prot    = 1'b0;
    assign bus.r_ready    = r_ready_r;

endmodule
